// File: rtl/operand_stager_pkg.sv
// Shared types and default sizing for the operand stager and the logic stage it feeds.
package operand_stager_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned DEF_CNT_W   = 8;

  // Inter-byte timer width; wide enough for the largest legal TIMEOUT (255).
  localparam int unsigned TMR_W = 8;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/operand_stager_if.sv
// Byte-stream input, operand-pair output and status bundle of the operand stager.
interface operand_stager_if
  import operand_stager_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             out_valid;
  logic             out_ready;
  logic             timeout_err;
  logic [CNT_W-1:0] pair_count;

  // Source/consumer side: drives bytes, abort and downstream ready.
  modport master (
    output in_data, in_valid, abort, out_ready,
    input  in_ready, a_out, b_out, out_valid, timeout_err, pair_count
  );

  // Stager side.
  modport slave (
    input  in_data, in_valid, abort, out_ready,
    output in_ready, a_out, b_out, out_valid, timeout_err, pair_count
  );

endinterface

// File: rtl/operand_stager_timer.sv
// Loadable up-counter with clear/enable and a terminal-count flag, for serial loaders.
module stage_timeout_timer
  import operand_stager_pkg::*;
#(
  parameter int unsigned W  = TMR_W,
  parameter int unsigned TC = DEF_TIMEOUT - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear beats load, load beats count-enable.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == W'(TC));

endmodule

// File: rtl/operand_stager.sv
// Collects a two-byte operand pair from a valid/ready byte stream and presents it
// to the logic stage until taken, with inter-byte timeout, abort and a pair counter.
module operand_stager
  import operand_stager_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic             clk,
  input logic             reset,
  operand_stager_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;
  logic in_ready;
  logic xfer;

  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign xfer     = bus.in_valid && in_ready;

  stage_timeout_timer #(
    .W  (TMR_W),
    .TC (TIMEOUT - 1)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (tmr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  // Next-state, operand capture, pair counting and timer control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;

    if (bus.abort) begin
      state_d = LOAD_A;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          // Timer held at zero so LOAD_B always starts counting from 0.
          tmr_clr = 1'b1;
          if (xfer) begin
            a_d     = bus.in_data;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          // A byte arriving on the terminal cycle takes precedence over the timeout.
          if (xfer) begin
            b_d     = bus.in_data;
            state_d = PRESENT;
          end else if (tmr_tc) begin
            terr_d  = 1'b1;
            tmr_clr = 1'b1;
            state_d = LOAD_A;
          end else begin
            tmr_en = 1'b1;
          end
        end
        PRESENT: begin
          tmr_clr = 1'b1;
          if (bus.out_ready) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = LOAD_A;
          end
        end
        default: begin
          state_d = LOAD_A;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  // State, operand, counter and error-pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.a_out       = a_q;
  assign bus.b_out       = b_q;
  assign bus.out_valid   = (state_q == PRESENT);
  assign bus.timeout_err = terr_q;
  assign bus.pair_count  = cnt_q;

endmodule

// File: tb/tb_operand_stager.sv
// Scoreboard bench for operand_stager: expected pairs are queued as bytes are
// driven and checked, with the running pair count, at each handoff.
module tb_operand_stager;

  logic clk;
  logic reset;

  operand_stager_if #(.WIDTH(8), .CNT_W(8)) bus ();

  operand_stager #(
    .WIDTH   (8),
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] sb_q[$];
  logic [7:0]  exp_count = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    sb_q.push_back({a, b});
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    cyc();
    bus.in_data   = b;
    cyc();
    bus.in_valid  = 1'b0;
    cyc();
  endtask

  // Handoff monitor: a pair leaves whenever out_valid && out_ready without abort.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready && !bus.abort) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pair", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("sb_a_out", {24'd0, bus.a_out}, {24'd0, e[15:8]});
        check("sb_b_out", {24'd0, bus.b_out}, {24'd0, e[7:0]});
        check("sb_pair_count", {24'd0, bus.pair_count}, {24'd0, exp_count});
      end
      exp_count = exp_count + 8'd1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] prev;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_a_out", {24'd0, bus.a_out}, 32'd0);
    check("rst_b_out", {24'd0, bus.b_out}, 32'd0);
    check("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    check("rst_pair_count", {24'd0, bus.pair_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // Basic pair
    sb_q.push_back(16'hF03C);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hF0;
    cyc();
    check("basic_a_captured", {24'd0, bus.a_out}, 32'hF0);
    check("basic_out_valid_lo", {31'd0, bus.out_valid}, 32'd0);
    bus.in_data = 8'h3C;
    cyc();
    check("basic_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("basic_in_ready_lo", {31'd0, bus.in_ready}, 32'd0);
    check("basic_b_out", {24'd0, bus.b_out}, 32'h3C);
    bus.in_valid = 1'b0;
    cyc();
    check("basic_out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check("basic_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    check("basic_pair_count", {24'd0, bus.pair_count}, 32'd1);

    // Backpressure
    sb_q.push_back(16'hAA55);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    cyc();
    bus.in_data = 8'h55;
    cyc();
    bus.in_data = 8'h11;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_a_hold", {24'd0, bus.a_out}, 32'hAA);
      check("bp_b_hold", {24'd0, bus.b_out}, 32'h55);
      cyc();
    end
    bus.out_ready = 1'b1;
    cyc();
    check("bp_pair_count", {24'd0, bus.pair_count}, 32'd2);
    check("bp_a_not_11_yet", {24'd0, bus.a_out}, 32'hAA);
    cyc();
    check("bp_next_a", {24'd0, bus.a_out}, 32'h11);
    sb_q.push_back(16'h1122);
    bus.in_data = 8'h22;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    check("bp_pair_count2", {24'd0, bus.pair_count}, 32'd3);

    // Timeout (TIMEOUT=4)
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h12;
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("to_no_err_early", {31'd0, bus.timeout_err}, 32'd0);
    end
    cyc();
    check("to_err_pulse", {31'd0, bus.timeout_err}, 32'd1);
    check("to_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("to_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("to_a_stale", {24'd0, bus.a_out}, 32'h12);
    check("to_count_same", {24'd0, bus.pair_count}, 32'd3);
    sb_q.push_back(16'h0102);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    cyc();
    check("to_err_one_cycle", {31'd0, bus.timeout_err}, 32'd0);
    check("to_new_a", {24'd0, bus.a_out}, 32'h01);
    bus.in_data = 8'h02;
    cyc();
    check("to_new_pair_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    cyc();

    // Timeout race: B arrives while timer==3
    sb_q.push_back(16'h3344);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    cyc();
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    cyc();
    check("race_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("race_no_err", {31'd0, bus.timeout_err}, 32'd0);
    check("race_b_out", {24'd0, bus.b_out}, 32'h44);
    bus.in_valid = 1'b0;
    cyc();
    check("race_no_err_after", {31'd0, bus.timeout_err}, 32'd0);

    // Abort priority in PRESENT with out_ready high
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5A;
    cyc();
    bus.in_data = 8'h66;
    cyc();
    bus.in_valid  = 1'b0;
    bus.abort     = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_count", {24'd0, bus.pair_count}, {24'd0, exp_count});
    check("abort_a_keep", {24'd0, bus.a_out}, 32'h5A);
    check("abort_b_keep", {24'd0, bus.b_out}, 32'h66);
    check("abort_no_err", {31'd0, bus.timeout_err}, 32'd0);
    // Abort in LOAD_A discards an offered byte
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    cyc();
    check("abort_drop_byte", {24'd0, bus.a_out}, 32'h5A);
    check("abort_stay_load_a", {31'd0, bus.out_valid}, 32'd0);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    cyc();

    // Counter wrap over 256 pairs
    prev = bus.pair_count;
    for (int i = 0; i < 256; i++) begin
      send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if (prev == 8'hFF) check("wrap_ff_to_00", {24'd0, bus.pair_count}, 32'd0);
      prev = bus.pair_count;
    end
    check("wrap_final_count", {24'd0, bus.pair_count}, {24'd0, exp_count});

    // Asynchronous reset mid-LOAD_B, not clock-aligned
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h9A;
    cyc();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_a_out", {24'd0, bus.a_out}, 32'd0);
    check("arst_b_out", {24'd0, bus.b_out}, 32'd0);
    check("arst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    check("arst_pair_count", {24'd0, bus.pair_count}, 32'd0);
    exp_count = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    cyc();
    send_pair(8'hC3, 8'h5F);
    check("post_rst_count", {24'd0, bus.pair_count}, 32'd1);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
